// File: rtl/node_pkg.sv
// Shared definitions for the EER-RL node sequencer: packet-type codes,
// round-phase encoding and the node word width.
package node_pkg;

  localparam int NODE_W = 16;

  localparam logic [2:0] PKT_HB        = 3'b000;
  localparam logic [2:0] PKT_CHE       = 3'b001;
  localparam logic [2:0] PKT_DATA      = 3'b010;
  localparam logic [2:0] PKT_RST_ROUND = 3'b100;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_SETUP  = 2'd1,
    PH_FORM   = 2'd2,
    PH_STEADY = 2'd3
  } phase_e;

endpackage

// File: rtl/tdma_slot_counter.sv
// TDMA slot/frame counter. Slot counts 0..NUM_SLOTS-1 on i_tick and wraps;
// the frame count advances on every wrap. i_clr has priority over i_tick.
module tdma_slot_counter
  import node_pkg::*;
#(
  parameter int NUM_SLOTS = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              i_clr,
  input  logic              i_tick,
  output logic [NODE_W-1:0] o_slot_cnt,
  output logic [NODE_W-1:0] o_frame_cnt,
  output logic              o_wrap
);

  localparam logic [NODE_W-1:0] LAST_SLOT = NODE_W'(NUM_SLOTS - 1);

  logic [NODE_W-1:0] r_slot;
  logic [NODE_W-1:0] r_frame;

  assign o_wrap      = i_tick && (r_slot == LAST_SLOT);
  assign o_slot_cnt  = r_slot;
  assign o_frame_cnt = r_frame;

  // Slot and frame counters: clear, or advance on a slot boundary.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_slot  <= '0;
      r_frame <= '0;
    end else if (i_clr) begin
      r_slot  <= '0;
      r_frame <= '0;
    end else if (i_tick) begin
      if (o_wrap) begin
        r_slot  <= '0;
        r_frame <= r_frame + 1'b1;
      end else begin
        r_slot <= r_slot + 1'b1;
      end
    end
  end

endmodule

// File: rtl/node_phase_ctrl.sv
// EER-RL per-node protocol sequencer: round phase FSM, node-info update
// strobe, TDMA slot tracking and radio tx/rx requests.
// Optional build macro LOW_E_RESIGN_EN: a low-energy cluster head drops
// from STEADY back to FORM at a frame wrap instead of finishing the round.
module node_phase_ctrl
  import node_pkg::*;
#(
  parameter int NUM_SLOTS        = 16,
  parameter int FORM_TIMEOUT     = 1024,
  parameter int FRAMES_PER_ROUND = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              pkt_valid,
  input  logic [2:0]        fPktType,
  input  logic              role,
  input  logic              low_E,
  input  logic [NODE_W-1:0] timeslot,
  input  logic              slot_tick,
  input  logic              tx_done,
  output logic              en_MNI,
  output logic [2:0]        pkt_type_o,
  output logic [1:0]        phase,
  output logic [NODE_W-1:0] slot_cnt,
  output logic              tx_req,
  output logic              rx_en,
  output logic              round_done
);

  localparam int                TMR_W      = $clog2(FORM_TIMEOUT) + 1;
  localparam logic [TMR_W-1:0]  TMR_LAST   = TMR_W'(FORM_TIMEOUT - 1);
  localparam logic [NODE_W-1:0] LAST_SLOT  = NODE_W'(NUM_SLOTS - 1);
  localparam logic [NODE_W-1:0] LAST_FRAME = NODE_W'(FRAMES_PER_ROUND - 1);

  phase_e            r_state;
  phase_e            w_state_nxt;
  logic [TMR_W-1:0]  r_form_tmr;
  logic              r_en_mni;
  logic [2:0]        r_pkt_type;
  logic              r_round_done;
  logic              r_tx_req;
  logic              r_tx_used;

  logic              w_is_rst;
  logic              w_is_hb;
  logic              w_is_che;
  logic              w_timeout;
  logic              w_tick;
  logic              w_wrap;
  logic              w_round_end;
  logic              w_resign;
  logic              w_my_slot;
  logic              w_fwd;
  logic              w_cnt_clr;
  logic              w_tmr_clr;
  logic              w_round_done_nxt;
  logic [NODE_W-1:0] w_slot_cnt;
  logic [NODE_W-1:0] w_frame_cnt;

  assign w_is_rst    = pkt_valid && (fPktType == PKT_RST_ROUND);
  assign w_is_hb     = pkt_valid && (fPktType == PKT_HB);
  assign w_is_che    = pkt_valid && (fPktType == PKT_CHE);
  assign w_timeout   = (r_state == PH_FORM) && (r_form_tmr == TMR_LAST);
  assign w_tick      = (r_state == PH_STEADY) && slot_tick;
  assign w_round_end = w_wrap && (w_frame_cnt == LAST_FRAME);

`ifdef LOW_E_RESIGN_EN
  assign w_resign = w_wrap && role && low_E;
`else
  // low_E does not influence sequencing in this build.
  assign w_resign = 1'b0 & low_E;
`endif

  // A cluster head owns the last slot; a member owns its assigned slot.
  assign w_my_slot = (r_state == PH_STEADY) &&
                     (role ? (w_slot_cnt == LAST_SLOT) : (w_slot_cnt == timeslot));

  tdma_slot_counter #(
    .NUM_SLOTS (NUM_SLOTS)
  ) u_slot_cnt (
    .clk         (clk),
    .nrst        (nrst),
    .i_clr       (w_cnt_clr),
    .i_tick      (w_tick),
    .o_slot_cnt  (w_slot_cnt),
    .o_frame_cnt (w_frame_cnt),
    .o_wrap      (w_wrap)
  );

  // Phase state register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= PH_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next phase and control strobes; RST_ROUND outranks timeout, which
  // outranks packet acceptance, which outranks slot events.
  always_comb begin
    w_state_nxt      = r_state;
    w_fwd            = 1'b0;
    w_cnt_clr        = 1'b0;
    w_tmr_clr        = 1'b0;
    w_round_done_nxt = 1'b0;
    if (w_is_rst) begin
      w_state_nxt = PH_SETUP;
      w_cnt_clr   = 1'b1;
      w_tmr_clr   = 1'b1;
    end else begin
      case (r_state)
        PH_IDLE: w_state_nxt = PH_SETUP;
        PH_SETUP: begin
          if (w_is_hb) begin
            w_fwd       = 1'b1;
            w_state_nxt = PH_FORM;
            w_tmr_clr   = 1'b1;
          end
        end
        PH_FORM: begin
          if (w_timeout) begin
            w_state_nxt = PH_SETUP;
            w_tmr_clr   = 1'b1;
          end else if (w_is_hb) begin
            w_fwd = 1'b1;
          end else if (w_is_che) begin
            w_fwd       = 1'b1;
            w_state_nxt = PH_STEADY;
            w_cnt_clr   = 1'b1;
          end
        end
        PH_STEADY: begin
          if (w_resign) begin
            w_state_nxt = PH_FORM;
            w_tmr_clr   = 1'b1;
            w_cnt_clr   = 1'b1;
          end else if (w_round_end) begin
            w_state_nxt      = PH_SETUP;
            w_cnt_clr        = 1'b1;
            w_round_done_nxt = 1'b1;
          end
        end
        default: w_state_nxt = PH_IDLE;
      endcase
    end
  end

  // Formation timer runs only while in FORM and restarts on each entry.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                  r_form_tmr <= '0;
    else if (w_tmr_clr)         r_form_tmr <= '0;
    else if (r_state == PH_FORM) r_form_tmr <= r_form_tmr + 1'b1;
  end

  // Registered node-info update strobe, packet type and round-end pulse.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_en_mni     <= 1'b0;
      r_pkt_type   <= '0;
      r_round_done <= 1'b0;
    end else begin
      r_en_mni     <= w_fwd;
      r_round_done <= w_round_done_nxt;
      if (w_fwd) r_pkt_type <= fPktType;
    end
  end

  // Transmit request: one grant per owned slot, released by tx_done or the
  // next slot boundary; r_tx_used stops re-raising after tx_done.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_tx_req  <= 1'b0;
      r_tx_used <= 1'b0;
    end else if (w_is_rst || (r_state != PH_STEADY) || w_tick) begin
      r_tx_req  <= 1'b0;
      r_tx_used <= 1'b0;
    end else if (r_tx_req && tx_done) begin
      r_tx_req <= 1'b0;
    end else if (w_my_slot && !r_tx_used) begin
      r_tx_req  <= 1'b1;
      r_tx_used <= 1'b1;
    end
  end

  assign rx_en = (r_state == PH_SETUP) || (r_state == PH_FORM) ||
                 ((r_state == PH_STEADY) && role && (w_slot_cnt != LAST_SLOT));

  assign en_MNI     = r_en_mni;
  assign pkt_type_o = r_pkt_type;
  assign phase      = r_state;
  assign slot_cnt   = w_slot_cnt;
  assign tx_req     = r_tx_req;
  assign round_done = r_round_done;

endmodule

// File: tb/tb_node_phase_ctrl.sv
// Directed bench for node_phase_ctrl with default parameters
// (NUM_SLOTS=16, FORM_TIMEOUT=1024, FRAMES_PER_ROUND=8).
module tb_node_phase_ctrl;

  logic        clk;
  logic        nrst;
  logic        pkt_valid;
  logic [2:0]  fPktType;
  logic        role;
  logic        low_E;
  logic [15:0] timeslot;
  logic        slot_tick;
  logic        tx_done;
  logic        en_MNI;
  logic [2:0]  pkt_type_o;
  logic [1:0]  phase;
  logic [15:0] slot_cnt;
  logic        tx_req;
  logic        rx_en;
  logic        round_done;

  int checks = 0;
  int errors = 0;

  node_phase_ctrl dut (
    .clk        (clk),
    .nrst       (nrst),
    .pkt_valid  (pkt_valid),
    .fPktType   (fPktType),
    .role       (role),
    .low_E      (low_E),
    .timeslot   (timeslot),
    .slot_tick  (slot_tick),
    .tx_done    (tx_done),
    .en_MNI     (en_MNI),
    .pkt_type_o (pkt_type_o),
    .phase      (phase),
    .slot_cnt   (slot_cnt),
    .tx_req     (tx_req),
    .rx_en      (rx_en),
    .round_done (round_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic [2:0] t);
    pkt_valid = 1'b1;
    fPktType  = t;
    step();
    pkt_valid = 1'b0;
  endtask

  task automatic do_tick();
    slot_tick = 1'b1;
    step();
    slot_tick = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0; pkt_valid = 0; fPktType = 0; role = 0; low_E = 0;
    timeslot = 0; slot_tick = 0; tx_done = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (phase !== 2'd0) begin errors++; $display("FAIL reset_phase got %0d exp 0", phase); end
    checks++; if (en_MNI !== 1'b0 || pkt_type_o !== 3'd0) begin errors++; $display("FAIL reset_mni got %b/%0d exp 0/0", en_MNI, pkt_type_o); end
    checks++; if (slot_cnt !== 16'd0 || tx_req !== 1'b0) begin errors++; $display("FAIL reset_slot_tx got %0d/%b exp 0/0", slot_cnt, tx_req); end
    checks++; if (rx_en !== 1'b0 || round_done !== 1'b0) begin errors++; $display("FAIL reset_rx_rd got %b/%b exp 0/0", rx_en, round_done); end
    nrst = 1'b1;
    step();
    checks++; if (phase !== 2'd1) begin errors++; $display("FAIL idle_to_setup got %0d exp 1", phase); end
    checks++; if (rx_en !== 1'b1) begin errors++; $display("FAIL setup_rx_en got %b exp 1", rx_en); end
  endtask

  task automatic test_hb();
    step(); step();
    send_pkt(3'b010);
    checks++; if (en_MNI !== 1'b0 || phase !== 2'd1) begin errors++; $display("FAIL data_ignored got en=%b ph=%0d exp en=0 ph=1", en_MNI, phase); end
    send_pkt(3'b000);
    checks++; if (en_MNI !== 1'b1 || pkt_type_o !== 3'b000) begin errors++; $display("FAIL hb_fwd got en=%b t=%0d exp en=1 t=0", en_MNI, pkt_type_o); end
    checks++; if (phase !== 2'd2) begin errors++; $display("FAIL hb_to_form got %0d exp 2", phase); end
  endtask

  task automatic test_timeout();
    int en_seen = 0;
    repeat (1023) begin
      step();
      if (en_MNI !== 1'b0) en_seen++;
    end
    checks++; if (en_seen != 0) begin errors++; $display("FAIL form_en_quiet got %0d exp 0", en_seen); end
    checks++; if (phase !== 2'd2) begin errors++; $display("FAIL form_before_timeout got %0d exp 2", phase); end
    step();
    checks++; if (phase !== 2'd1) begin errors++; $display("FAIL form_timeout got %0d exp 1", phase); end
  endtask

  task automatic test_che();
    send_pkt(3'b000);
    checks++; if (phase !== 2'd2) begin errors++; $display("FAIL che_enter_form got %0d exp 2", phase); end
    send_pkt(3'b000);
    checks++; if (en_MNI !== 1'b1 || phase !== 2'd2) begin errors++; $display("FAIL hb_in_form got en=%b ph=%0d exp en=1 ph=2", en_MNI, phase); end
    send_pkt(3'b001);
    checks++; if (en_MNI !== 1'b1 || pkt_type_o !== 3'b001) begin errors++; $display("FAIL che_fwd got en=%b t=%0d exp en=1 t=1", en_MNI, pkt_type_o); end
    checks++; if (phase !== 2'd3 || slot_cnt !== 16'd0) begin errors++; $display("FAIL che_to_steady got ph=%0d s=%0d exp ph=3 s=0", phase, slot_cnt); end
    checks++; if (rx_en !== 1'b0 || tx_req !== 1'b0) begin errors++; $display("FAIL member_steady_rx got rx=%b tx=%b exp 0/0", rx_en, tx_req); end
    step();
    checks++; if (en_MNI !== 1'b0 || pkt_type_o !== 3'b001) begin errors++; $display("FAIL en_mni_pulse got en=%b t=%0d exp en=0 t=1", en_MNI, pkt_type_o); end
  endtask

  task automatic test_member_tx();
    role = 1'b0; timeslot = 16'd3;
    for (int s = 1; s <= 3; s++) begin
      do_tick();
      if (s < 3) repeat (9) step();
    end
    checks++; if (slot_cnt !== 16'd3 || tx_req !== 1'b0) begin errors++; $display("FAIL slot3_entry got s=%0d tx=%b exp s=3 tx=0", slot_cnt, tx_req); end
    step();
    checks++; if (tx_req !== 1'b1) begin errors++; $display("FAIL member_tx_rise got %b exp 1", tx_req); end
    repeat (3) step();
    checks++; if (tx_req !== 1'b1) begin errors++; $display("FAIL member_tx_hold got %b exp 1", tx_req); end
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    checks++; if (tx_req !== 1'b0) begin errors++; $display("FAIL tx_done_release got %b exp 0", tx_req); end
    repeat (4) step();
    checks++; if (tx_req !== 1'b0) begin errors++; $display("FAIL tx_no_rearm got %b exp 0", tx_req); end
    // Next frame: release by slot boundary instead of tx_done.
    for (int i = 0; i < 16; i++) begin
      do_tick();
      if (i == 12) begin
        checks++; if (slot_cnt !== 16'd0) begin errors++; $display("FAIL member_wrap got %0d exp 0", slot_cnt); end
      end
      if (i < 15) repeat (3) step();
    end
    checks++; if (slot_cnt !== 16'd3 || tx_req !== 1'b0) begin errors++; $display("FAIL frame1_slot3 got s=%0d tx=%b exp s=3 tx=0", slot_cnt, tx_req); end
    step();
    checks++; if (tx_req !== 1'b1) begin errors++; $display("FAIL frame1_tx_rise got %b exp 1", tx_req); end
    step(); step();
    do_tick();
    checks++; if (tx_req !== 1'b0 || slot_cnt !== 16'd4) begin errors++; $display("FAIL tick_release got tx=%b s=%0d exp tx=0 s=4", tx_req, slot_cnt); end
  endtask

  task automatic test_rst_round();
    for (int i = 0; i < 15; i++) begin
      do_tick();
      if (i < 14) repeat (2) step();
    end
    step();
    checks++; if (tx_req !== 1'b1 || slot_cnt !== 16'd3) begin errors++; $display("FAIL pre_rst_tx got tx=%b s=%0d exp tx=1 s=3", tx_req, slot_cnt); end
    pkt_valid = 1'b1; fPktType = 3'b100; slot_tick = 1'b1;
    step();
    pkt_valid = 1'b0; slot_tick = 1'b0;
    checks++; if (phase !== 2'd1 || slot_cnt !== 16'd0) begin errors++; $display("FAIL rst_round_phase got ph=%0d s=%0d exp ph=1 s=0", phase, slot_cnt); end
    checks++; if (tx_req !== 1'b0 || en_MNI !== 1'b0) begin errors++; $display("FAIL rst_round_tx got tx=%b en=%b exp 0/0", tx_req, en_MNI); end
  endtask

  task automatic test_cluster_head();
    role = 1'b1;
    send_pkt(3'b000);
    send_pkt(3'b001);
    step();
    checks++; if (phase !== 2'd3 || rx_en !== 1'b1 || tx_req !== 1'b0) begin errors++; $display("FAIL ch_slot0 got ph=%0d rx=%b tx=%b exp 3/1/0", phase, rx_en, tx_req); end
    for (int s = 1; s <= 15; s++) begin
      do_tick();
      step();
      checks++;
      if (s < 15) begin
        if (slot_cnt !== 16'(s) || rx_en !== 1'b1 || tx_req !== 1'b0) begin errors++; $display("FAIL ch_slot%0d got s=%0d rx=%b tx=%b exp rx=1 tx=0", s, slot_cnt, rx_en, tx_req); end
      end else begin
        if (slot_cnt !== 16'd15 || rx_en !== 1'b0 || tx_req !== 1'b1) begin errors++; $display("FAIL ch_slot15 got s=%0d rx=%b tx=%b exp s=15 rx=0 tx=1", slot_cnt, rx_en, tx_req); end
      end
    end
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    checks++; if (tx_req !== 1'b0) begin errors++; $display("FAIL ch_tx_done got %b exp 0", tx_req); end
    do_tick();
    checks++; if (slot_cnt !== 16'd0 || rx_en !== 1'b1 || phase !== 2'd3 || round_done !== 1'b0) begin errors++; $display("FAIL ch_wrap got s=%0d rx=%b ph=%0d rd=%b exp 0/1/3/0", slot_cnt, rx_en, phase, round_done); end
  endtask

  task automatic test_round();
    int rd_cnt = 0;
    int tx_cnt = 0;
    role = 1'b0; timeslot = 16'd20;
    send_pkt(3'b100);
    checks++; if (phase !== 2'd1) begin errors++; $display("FAIL round_rst got %0d exp 1", phase); end
    send_pkt(3'b000);
    send_pkt(3'b001);
    for (int i = 0; i < 128; i++) begin
      if (i == 127) begin
        checks++; if (phase !== 2'd3 || slot_cnt !== 16'd15) begin errors++; $display("FAIL pre_round_end got ph=%0d s=%0d exp 3/15", phase, slot_cnt); end
      end
      do_tick();
      if (round_done === 1'b1) rd_cnt++;
      if (tx_req === 1'b1) tx_cnt++;
      if (i == 127) begin
        checks++; if (round_done !== 1'b1 || phase !== 2'd1 || slot_cnt !== 16'd0) begin errors++; $display("FAIL round_end got rd=%b ph=%0d s=%0d exp 1/1/0", round_done, phase, slot_cnt); end
      end
      repeat (2) begin
        step();
        if (round_done === 1'b1) rd_cnt++;
        if (tx_req === 1'b1) tx_cnt++;
      end
    end
    checks++; if (rd_cnt != 1) begin errors++; $display("FAIL round_done_count got %0d exp 1", rd_cnt); end
    checks++; if (tx_cnt != 0) begin errors++; $display("FAIL oob_timeslot_tx got %0d exp 0", tx_cnt); end
    do_tick();
    checks++; if (slot_cnt !== 16'd0 || phase !== 2'd1) begin errors++; $display("FAIL tick_in_setup got s=%0d ph=%0d exp 0/1", slot_cnt, phase); end
  endtask

  task automatic test_low_e();
    role = 1'b1; low_E = 1'b1; timeslot = 16'd0;
    send_pkt(3'b000);
    send_pkt(3'b001);
    for (int i = 0; i < 16; i++) begin
      do_tick();
      if (i < 15) step();
    end
`ifdef LOW_E_RESIGN_EN
    checks++; if (phase !== 2'd2 || round_done !== 1'b0 || rx_en !== 1'b1) begin errors++; $display("FAIL low_e_resign got ph=%0d rd=%b rx=%b exp 2/0/1", phase, round_done, rx_en); end
`else
    checks++; if (phase !== 2'd3 || slot_cnt !== 16'd0 || round_done !== 1'b0) begin errors++; $display("FAIL low_e_no_effect got ph=%0d s=%0d rd=%b exp 3/0/0", phase, slot_cnt, round_done); end
`endif
    low_E = 1'b0;
  endtask

  task automatic test_async_reset();
    role = 1'b0; timeslot = 16'd0;
    send_pkt(3'b100);
    send_pkt(3'b000);
    send_pkt(3'b001);
    step();
    checks++; if (tx_req !== 1'b1) begin errors++; $display("FAIL slot0_tx got %b exp 1", tx_req); end
    @(negedge clk);
    nrst = 1'b0;
    #1;
    checks++; if (tx_req !== 1'b0 || phase !== 2'd0) begin errors++; $display("FAIL async_reset got tx=%b ph=%0d exp 0/0", tx_req, phase); end
    step();
    nrst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_hb();
    test_timeout();
    test_che();
    test_member_tx();
    test_rst_round();
    test_cluster_head();
    test_round();
    test_low_e();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
